// File: rtl/wb_master_if_pkg.sv
// Shared definitions for the Wishbone classic-cycle initiator: FSM states,
// bus width defaults and the timeout counter sizing helper.
package wb_master_if_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam logic [WB_DW-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } wb_state_e;

  // A zero-wide counter is illegal, so a disabled timeout still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_master_if_timeout_cnt.sv
// Saturating cycle counter with synchronous clear and count enable; flags the
// last permitted wait cycle so the initiator can abort an unanswered access.
module wb_master_if_timeout_cnt
  import wb_master_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    tc_o = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/wb_master_if.sv
// Wishbone classic-cycle initiator: turns one held core load/store request into
// a single bus read or write, reporting completion, bus error or timeout.
module wb_master_if
  import wb_master_if_pkg::*;
#(
  parameter int unsigned AW      = WB_AW,
  parameter int unsigned DW      = WB_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cpu_req_i,
  input  logic            cpu_we_i,
  input  logic [AW-1:0]   cpu_addr_i,
  input  logic [DW-1:0]   cpu_wdata_i,
  input  logic [DW/8-1:0] cpu_sel_i,
  output logic [DW-1:0]   cpu_rdata_o,
  output logic            cpu_done_o,
  output logic            cpu_err_o,
  output logic            cpu_stall_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_stb_o,
  output logic            wb_cyc_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  wb_state_e       state_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [DW/8-1:0] sel_q;
  logic            we_q;
  logic            cyc_q;
  logic [DW-1:0]   rdata_q;
  logic            done_q;
  logic            err_q;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_tc;

  assign tmo_clr = (state_q == ST_IDLE) && cpu_req_i;
  assign tmo_en  = (state_q == ST_ACTIVE);

  wb_master_if_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .clr_i(tmo_clr),
    .en_i (tmo_en),
    .tc_o (tmo_tc)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= DW'(ZERO_WORD);
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdata_q <= DW'(ZERO_WORD);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req_i) begin
            adr_q   <= cpu_addr_i;
            dat_q   <= cpu_wdata_i;
            sel_q   <= cpu_sel_i;
            we_q    <= cpu_we_i;
            cyc_q   <= 1'b1;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // err outranks ack so a conflicting response never returns data
          if (wb_err_i) begin
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            if (!we_q) begin
              rdata_q <= wb_dat_i;
            end
            state_q <= ST_DONE;
          end else if (tmo_tc) begin
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_done_o  = done_q;
  assign cpu_err_o   = err_q;
  assign cpu_stall_o = cpu_req_i & ~done_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Self-checking bench for wb_master_if: a multi-region Wishbone responder plus
// a transaction-level model of expected latency, error and read data.
module tb_wb_master_if;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic        done, err, stall;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_master_if #(
    .AW(32),
    .DW(32),
    .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cpu_req_i  (req),
    .cpu_we_i   (we),
    .cpu_addr_i (addr),
    .cpu_wdata_i(wdata),
    .cpu_sel_i  (sel),
    .cpu_rdata_o(rdata),
    .cpu_done_o (done),
    .cpu_err_o  (err),
    .cpu_stall_o(stall),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel),
    .wb_we_o    (wb_we),
    .wb_stb_o   (wb_stb),
    .wb_cyc_o   (wb_cyc),
    .wb_ack_i   (wb_ack),
    .wb_err_i   (wb_err)
  );

  // Responder map by addr[31:28]: 0 registered-ack RAM, 1 combinational-ack
  // RAM alias, 2 registered err, 3 registered ack+err, anything else silent.
  logic [31:0] mem [16] = '{default: '0};
  logic        resp_r;
  logic [3:0]  rgn;
  logic [3:0]  widx;

  assign rgn  = wb_adr[31:28];
  assign widx = wb_adr[5:2];

  always @(posedge clk or posedge rst) begin
    if (rst) resp_r <= 1'b0;
    else     resp_r <= wb_cyc & wb_stb & ~resp_r &
                       ((rgn == 4'd0) | (rgn == 4'd2) | (rgn == 4'd3));
  end

  assign wb_ack   = (((rgn == 4'd0) | (rgn == 4'd3)) & resp_r) |
                    ((rgn == 4'd1) & wb_cyc & wb_stb);
  assign wb_err   = ((rgn == 4'd2) | (rgn == 4'd3)) & resp_r;
  assign wb_dat_i = (rgn <= 4'd1) ? mem[widx] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (wb_cyc & wb_stb & wb_we & wb_ack & ~wb_err)
      for (int b = 0; b < 4; b++)
        if (wb_sel[b]) mem[widx][8*b +: 8] <= wb_dat_o[8*b +: 8];
  end

  // Reference model state
  logic [31:0] exp_mem [16];
  logic [31:0] exp_rdata;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Entered and left just after a rising edge; the request is seen at the next edge.
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr,
                         input logic [31:0] t_wd, input logic [3:0] t_sel,
                         input bit keep);
    int          lat, done_edge, cyc_cnt;
    logic        exp_err;
    logic [3:0]  r, ix;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd; sel = t_sel;
    r  = t_addr[31:28];
    ix = t_addr[5:2];
    case (r)
      4'd0, 4'd2, 4'd3: lat = 2;
      4'd1:             lat = 1;
      default:          lat = TMO;
    endcase
    exp_err = !((r == 4'd0) || (r == 4'd1));

    @(negedge clk);
    check_eq("idle_cyc", 32'(wb_cyc), 32'd0);
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("stall_wait", 32'(stall), 32'd1);

    done_edge = -1;
    cyc_cnt   = 0;
    for (int k = 0; k < TMO + 6 && done_edge < 0; k++) begin
      @(negedge clk);
      check_eq("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
      if (wb_cyc) begin
        cyc_cnt++;
        check_eq("bus_adr", wb_adr, t_addr);
        check_eq("bus_we", 32'(wb_we), 32'(t_we));
        check_eq("bus_sel", 32'(wb_sel), 32'(t_sel));
        if (t_we) check_eq("bus_dat", wb_dat_o, t_wd);
      end
      if (done) begin
        done_edge = k;
        check_eq("stall_done", 32'(stall), 32'd0);
        check_eq("err", 32'(err), 32'(exp_err));
      end
    end
    check_eq("done_latency", 32'(done_edge), 32'(lat));
    check_eq("cyc_cycles", 32'(cyc_cnt), 32'(lat));

    if (!exp_err) begin
      if (t_we) exp_mem[ix] = merge_bytes(exp_mem[ix], t_wd, t_sel);
      else      exp_rdata   = exp_mem[ix];
    end
    check_eq("rdata", rdata, exp_rdata);

    @(posedge clk); #1;
    if (!keep) begin
      req = 1'b0;
      @(negedge clk);
      check_eq("done_once", 32'(done), 32'd0);
      check_eq("cyc_after", 32'(wb_cyc), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [3:0]  r4, ix4;
    int          pick;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    exp_rdata = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;

    #1;
    check_eq("rst_cyc", 32'(wb_cyc), 32'd0);
    check_eq("rst_stb", 32'(wb_stb), 32'd0);
    check_eq("rst_we", 32'(wb_we), 32'd0);
    check_eq("rst_adr", wb_adr, 32'd0);
    check_eq("rst_dat", wb_dat_o, 32'd0);
    check_eq("rst_sel", 32'(wb_sel), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_txn(1'b1, 32'h0000_0004, 32'h0000_0002, 4'hF, 1'b0);
    run_txn(1'b0, 32'h0000_0004, 32'h0,        4'hF, 1'b0);
    run_txn(1'b1, 32'h0000_0020, 32'hDEADBEEF, 4'b0011, 1'b0);
    run_txn(1'b0, 32'h1000_0020, 32'h0,        4'hF, 1'b0);
    run_txn(1'b0, 32'h4000_0010, 32'h0,        4'hF, 1'b0);
    run_txn(1'b0, 32'h3000_0004, 32'h0,        4'hF, 1'b0);
    run_txn(1'b1, 32'h2000_0004, 32'h12345678, 4'hF, 1'b0);
    run_txn(1'b1, 32'h0000_0008, 32'h11223344, 4'hF, 1'b1);
    run_txn(1'b0, 32'h0000_0008, 32'h0,        4'hF, 1'b0);

    // Randomized traffic, some back-to-back with req held
    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 5));
      if (pick == 5)      r4 = 4'd0;
      else if (pick == 4) r4 = 4'($urandom_range(4, 15));
      else                r4 = 4'(pick);
      ix4 = 4'($urandom_range(0, 15));
      run_txn(1'($urandom_range(0, 1)), {r4, 22'($urandom), ix4, 2'b00},
              $urandom, 4'($urandom_range(1, 15)),
              (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Asynchronous reset in the middle of a timed-out access
    req = 1'b1; we = 1'b0; addr = 32'h5000_0010; wdata = '0; sel = 4'hF;
    repeat (3) @(posedge clk);
    #3;
    check_eq("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_cyc", 32'(wb_cyc), 32'd0);
    check_eq("arst_stb", 32'(wb_stb), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_rdata", rdata, 32'd0);
    exp_rdata = '0;
    req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0);
    run_txn(1'b0, 32'h1000_0004, 32'h0, 4'hF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_master_if.md
# wb_master_if

Wishbone classic-cycle initiator that turns one core-side load/store request into a single Wishbone read or write. It sits between the memory stage and the shared Wishbone interconnect, which also hosts the PLIC, UART and GPIO responders. It stalls the pipeline until the responder acks. A timeout counter aborts cycles to unmapped addresses with an error instead of hanging the core.

## Interface
- AW, 32, address width
- DW, 32, data width; byte selects are DW/8
- TIMEOUT, 255, cycles to wait for ack/err before aborting; 0 disables the timeout
- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  request valid; level, held with stable fields until cpu_done_o
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  AW  byte address
- cpu_wdata_i  in  DW  write data
- cpu_sel_i  in  DW/8  byte enables
- cpu_rdata_o  out  DW  read data, valid with cpu_done_o on a successful read
- cpu_done_o  out  1  one-cycle completion pulse
- cpu_err_o  out  1  pulses with cpu_done_o on wb_err_i or timeout
- cpu_stall_o  out  1  combinational: cpu_req_i & ~cpu_done_o
- wb_adr_o  out  AW  registered address
- wb_dat_o  out  DW  registered write data
- wb_dat_i  in  DW  read data from responder
- wb_sel_o  out  DW/8  registered byte selects
- wb_we_o  out  1  registered write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  responder ack
- wb_err_i  in  1  responder error

## Operation
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - On cpu_req_i=1, latch addr, wdata, sel and we into the wb_*_o registers.
  - Set wb_cyc_o = wb_stb_o = 1 and clear the timeout counter, then go to ACTIVE.
- ACTIVE: cyc and stb stay high, and the counter increments each cycle. Exit conditions, highest priority first:
  - wb_err_i=1: drop cyc/stb, set err, go to DONE.
  - wb_ack_i=1: drop cyc/stb. On a read, capture wb_dat_i into cpu_rdata_o. Go to DONE.
  - Counter == TIMEOUT-1 (TIMEOUT≠0): drop cyc/stb, set err, go to DONE.
- DONE:
  - cpu_done_o=1 for exactly this cycle; cpu_err_o=1 if an error was set.
  - Go to IDLE unconditionally.
  - The requester drops or changes cpu_req_i on this edge. The extra cycle prevents re-issuing a stale request while the responder's ack is still high.
- cpu_rdata_o holds its value across writes and errored or timed-out cycles.
- wb_ack_i and wb_err_i are ignored outside ACTIVE.
- Simultaneous ack and err: err wins, and no read data is captured.
- Changing cpu_req_i fields during ACTIVE has no effect, because the bus fields are latched.
- Counter width: clog2(TIMEOUT+1). It saturates and does not wrap.

## Timing
- Reset (async assert) values:
  - State IDLE; wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o = 0.
  - cpu_rdata_o = 0; cpu_done_o = cpu_err_o = 0; counter = 0.
- Reset mid-cycle: cyc/stb fall immediately and no done pulse is produced. Deassertion is sampled on a rising edge.
- With a responder that registers its ack one cycle after stb (the PLIC and peripheral convention):
  - Request seen at edge 0.
  - cyc/stb high from edge 0 to edge 2.
  - Ack seen at edge 2.
  - cpu_done_o high between edges 2 and 3.
  - Result: 3-cycle latency and one transaction every 4 cycles.
- A responder that acks combinationally in the first ACTIVE cycle gives 2-cycle latency.
- Timeout: cpu_done_o/cpu_err_o assert TIMEOUT+1 cycles after the request edge.
- wb_stb_o always equals wb_cyc_o. There are no bursts and no pipelined-mode stall.

## Structure
- The shared package (defines.v include) holds:
  - FSM state encodings (IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2).
  - Bus width constants.
  - `ZeroWord.
- Optional sub-module wb_timeout_cnt: saturating counter with clear, enable and terminal-count output. Everything else is one module.

## Test plan
- Read from the PLIC enable register after writing 32'h00000002: cpu_rdata_o = 32'h00000002 with cpu_done_o exactly 3 cycles after req, and cyc/stb high for exactly 2 cycles.
- Write 32'hDEADBEEF with sel=4'b0011 to a RAM model: wb_dat_o/wb_sel_o match for the whole cycle, wb_we_o=1, done pulses once, and cpu_rdata_o is unchanged.
- Read an unmapped address with TIMEOUT=8: cyc drops after 8 ACTIVE cycles, and cpu_done_o = cpu_err_o = 1 for one cycle.
- Responder asserts ack and err together on a read: cpu_err_o=1 and cpu_rdata_o keeps its previous value.
- Two back-to-back requests (req held, fields changed at the done edge): two distinct bus cycles with one idle cycle between them, and no duplicate of the first.
- Assert wb_rst_i during ACTIVE: cyc/stb drop without a clock edge, no done pulse; after release, a new request completes normally.
